// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
package pipe_pkg;

  // Stage fill state: how many beats the stage currently holds.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Default field widths for the per-stage registers.
  localparam int unsigned XLEN          = 32;
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned EX_MEM_CTRL_W = 5;
  localparam int unsigned MEM_WB_CTRL_W = 3;

  // Beat count held by a stage given its two slot valid bits.
  function automatic logic [1:0] beat_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + control + data register with load and clear.
// Clear has priority over load and always zeroes valid and control, so an
// empty slot presents a bubble. Data is cleared only when CLR_DATA=1.
module pipe_slot #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CTRL_W   = 8,
  parameter bit          CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Valid and control: reset/clear to a bubble, otherwise load new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
    end
  end

  generate
    if (CLR_DATA) begin : g_data_clr
      // Data register zeroed on reset and clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data <= '0;
        end else if (clear) begin
          data <= '0;
        end else if (load) begin
          data <= d_data;
        end
      end
    end else begin : g_data_hold
      // Data register without reset; holds its value when the slot empties.
      always_ff @(posedge clk) begin
        if (load && !clear) begin
          data <= d_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake and an optional
// 2-entry skid buffer (main slot = head beat, skid slot = younger beat).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = XLEN,
  parameter int unsigned CTRL_W   = ID_EX_CTRL_W,
  parameter bit          SKID     = 1'b1,
  parameter bit          CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic              accept, drain;
  logic              main_load, main_clr, skid_load, skid_clr;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign drain = main_valid & out_ready;
  assign accept = in_valid & in_ready & ~flush;

  // Next state and slot load/clear strobes; flush overrides everything.
  // With SKID=0 the in_ready equation guarantees ONE+accept implies drain,
  // so the same decode never reaches FULL and never loads the skid slot.
  always_comb begin
    state_d     = state_q;
    main_load   = 1'b0;
    main_clr    = flush;
    skid_load   = 1'b0;
    skid_clr    = flush;
    main_d_ctrl = in_ctrl;
    main_d_data = in_data;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (drain) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_load   = 1'b1;
            main_d_ctrl = skid_ctrl;
            main_d_data = skid_data;
            skid_clr    = 1'b1;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Fill-state register and registered in_ready (ready unless going FULL).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (main_load),
    .clear  (main_clr),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
      ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .clear  (skid_clr),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
      );
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = out_ready | ~main_valid;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = beat_count(main_valid, skid_valid);

endmodule
